player_ctrl: RTL and testbench

Parametrised player controller for the arena: the successor to the single-life bomberman mover. It owns the sprite position, step pacing, facing, lives and post-hit invulnerability, and game-over. It takes button levels, per-direction block flags, explosion and enemy-contact pulses and the VGA pixel position. It drives the sprite position and a pixel-hit flag to the top module / sprite ROM, plus lives and state flags to the HUD.

---
 rtl/player_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_player_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// player_ctrl
//   Arena player controller: owns the sprite position, step pacing, facing,
//   lives, post-hit invulnerability and game-over.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   L, U, R, D   button levels
//   blocked      per-direction block flags [0]=left [1]=right [2]=up [3]=down
//   explosion_p  single-cycle explosion pulse, centre tile at (e_x, e_y)
//   enemy_p      single-cycle enemy-contact pulse
//   v_x, v_y     current VGA pixel
//   b_x, b_y     sprite top-left
//   facing       0=down 1=up 2=left 3=right
//   moving       exactly one direction held and not dead
//   lives        remaining lives
//   invuln       post-hit invulnerability active
//   game_over    sticky until reset
//   sprite_on    current pixel lies inside the sprite box

module player_ctrl #(
    parameter int MIN_X        = 143,
    parameter int MAX_X        = 784,
    parameter int MIN_Y        = 34,
    parameter int MAX_Y        = 516,
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int START_X      = 143,
    parameter int START_Y      = 34,
    parameter int STEP_TICKS   = 1400000,
    parameter int LIVES        = 3,
    parameter int INVULN_TICKS = 50000000,
    parameter int ARM          = 48,
    parameter int TILE         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       U,
    input  logic       R,
    input  logic       D,
    input  logic [3:0] blocked,
    input  logic       explosion_p,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    input  logic       enemy_p,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] b_x,
    output logic [9:0] b_y,
    output logic [1:0] facing,
    output logic       moving,
    output logic [3:0] lives,
    output logic       invuln,
    output logic       game_over,
    output logic       sprite_on
);

    localparam int STEP_W = $clog2(STEP_TICKS + 1);
    localparam int INV_W  = $clog2(INVULN_TICKS + 1);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [9:0] X_LO = 10'(MIN_X);
    localparam logic [9:0] X_HI = 10'(MAX_X - SPR_W);
    localparam logic [9:0] Y_LO = 10'(MIN_Y);
    localparam logic [9:0] Y_HI = 10'(MAX_Y - SPR_H);

    localparam logic [11:0] W_M1  = 12'(SPR_W - 1);
    localparam logic [11:0] H_M1  = 12'(SPR_H - 1);
    localparam logic [11:0] T_M1  = 12'(TILE - 1);
    localparam logic [11:0] ARM12 = 12'(ARM);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVULN_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HIT   = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [STEP_W-1:0] step_cnt, step_next, step_eff;
    logic [INV_W-1:0]  inv_cnt, inv_next;
    logic [3:0]        lives_next;
    logic [1:0]        dir, last_dir;
    logic              dir_valid, last_valid;
    logic              fresh, step_wrap, can_move, hit, h_beam, v_beam;
    logic [9:0]        bx_next, by_next;
    logic [11:0]       bx12, by12, ex12, ey12, vx12, vy12;

    always_comb begin
        dir       = DIR_DOWN;
        dir_valid = 1'b0;
        unique case ({L, U, R, D})
            4'b1000: begin dir = DIR_LEFT;  dir_valid = 1'b1; end
            4'b0100: begin dir = DIR_UP;    dir_valid = 1'b1; end
            4'b0010: begin dir = DIR_RIGHT; dir_valid = 1'b1; end
            4'b0001: begin dir = DIR_DOWN;  dir_valid = 1'b1; end
            default: begin dir = DIR_DOWN;  dir_valid = 1'b0; end
        endcase
    end

    // A new or changed direction restarts the count on the press cycle
    // itself, so that cycle is the first of STEP_TICKS and the first move
    // lands exactly STEP_TICKS cycles after the press.
    always_comb begin
        fresh     = !last_valid || (last_dir != dir);
        step_eff  = fresh ? '0 : step_cnt;
        step_wrap = dir_valid && (state != ST_DEAD) && (step_eff == STEP_LAST);
        if (!dir_valid || (state == ST_DEAD) || step_wrap) begin
            step_next = '0;
        end else begin
            step_next = step_eff + 1'b1;
        end
    end

    always_comb begin
        can_move = 1'b0;
        bx_next  = b_x;
        by_next  = b_y;
        unique case (dir)
            DIR_LEFT:  can_move = !blocked[0] && (b_x > X_LO);
            DIR_RIGHT: can_move = !blocked[1] && (b_x < X_HI);
            DIR_UP:    can_move = !blocked[2] && (b_y > Y_LO);
            DIR_DOWN:  can_move = !blocked[3] && (b_y < Y_HI);
            default:   can_move = 1'b0;
        endcase
        if (step_wrap && can_move) begin
            unique case (dir)
                DIR_LEFT:  bx_next = b_x - 10'd1;
                DIR_RIGHT: bx_next = b_x + 10'd1;
                DIR_UP:    by_next = b_y - 10'd1;
                DIR_DOWN:  by_next = b_y + 10'd1;
                default:   bx_next = b_x;
            endcase
        end
    end

    // Beam overlap in 12 bits with every subtraction moved to the other side
    // of the comparison, so beams near the arena edge never wrap.
    always_comb begin
        bx12   = {2'b00, b_x};
        by12   = {2'b00, b_y};
        ex12   = {2'b00, e_x};
        ey12   = {2'b00, e_y};
        vx12   = {2'b00, v_x};
        vy12   = {2'b00, v_y};
        h_beam = (bx12 <= ex12 + T_M1 + ARM12) && (ex12 <= bx12 + W_M1 + ARM12) &&
                 (by12 <= ey12 + T_M1)         && (ey12 <= by12 + H_M1);
        v_beam = (bx12 <= ex12 + T_M1)         && (ex12 <= bx12 + W_M1) &&
                 (by12 <= ey12 + T_M1 + ARM12) && (ey12 <= by12 + H_M1 + ARM12);
        hit    = (state == ST_ALIVE) &&
                 (enemy_p || (explosion_p && (h_beam || v_beam)));
        sprite_on = (vx12 >= bx12) && (vx12 <= bx12 + W_M1) &&
                    (vy12 >= by12) && (vy12 <= by12 + H_M1);
    end

    always_comb begin
        state_next = state;
        inv_next   = inv_cnt;
        lives_next = lives;
        unique case (state)
            ST_ALIVE: begin
                if (hit) begin
                    lives_next = lives - 4'd1;
                    inv_next   = '0;
                    state_next = (lives > 4'd1) ? ST_HIT : ST_DEAD;
                end
            end
            ST_HIT: begin
                if (inv_cnt == INV_LAST) begin
                    inv_next   = '0;
                    state_next = ST_ALIVE;
                end else begin
                    inv_next = inv_cnt + 1'b1;
                end
            end
            ST_DEAD: begin
                lives_next = 4'd0;
            end
            default: begin
                state_next = ST_ALIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ALIVE;
            b_x        <= 10'(START_X);
            b_y        <= 10'(START_Y);
            facing     <= DIR_DOWN;
            lives      <= 4'(LIVES);
            step_cnt   <= '0;
            inv_cnt    <= '0;
            last_dir   <= DIR_DOWN;
            last_valid <= 1'b0;
        end else begin
            state      <= state_next;
            b_x        <= bx_next;
            b_y        <= by_next;
            lives      <= lives_next;
            step_cnt   <= step_next;
            inv_cnt    <= inv_next;
            last_dir   <= dir;
            last_valid <= dir_valid;
            if (dir_valid) begin
                facing <= dir;
            end
        end
    end

    assign moving    = dir_valid && (state != ST_DEAD);
    assign invuln    = (state == ST_HIT);
    assign game_over = (state == ST_DEAD);

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl
//   Self-checking bench for player_ctrl with STEP_TICKS=4, INVULN_TICKS=8,
//   LIVES=3. Expected values are queued as stimulus is driven, observed
//   values are queued after the DUT responds, and each task drains both.

module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       L, U, R, D;
    logic [3:0] blocked;
    logic       explosion_p, enemy_p;
    logic [9:0] e_x, e_y, v_x, v_y;
    logic [9:0] b_x, b_y;
    logic [1:0] facing;
    logic       moving, invuln, game_over, sprite_on;
    logic [3:0] lives;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    int          errors = 0;
    int          checks = 0;

    player_ctrl #(
        .STEP_TICKS  (4),
        .INVULN_TICKS(8),
        .LIVES       (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .L          (L),
        .U          (U),
        .R          (R),
        .D          (D),
        .blocked    (blocked),
        .explosion_p(explosion_p),
        .e_x        (e_x),
        .e_y        (e_y),
        .enemy_p    (enemy_p),
        .v_x        (v_x),
        .v_y        (v_y),
        .b_x        (b_x),
        .b_y        (b_y),
        .facing     (facing),
        .moving     (moving),
        .lives      (lives),
        .invuln     (invuln),
        .game_over  (game_over),
        .sprite_on  (sprite_on)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sb.push_back('{"reset b_x", 32'd143});
        sb.push_back('{"reset b_y", 32'd34});
        sb.push_back('{"reset facing", 32'd0});
        sb.push_back('{"reset moving", 32'd0});
        sb.push_back('{"reset lives", 32'd3});
        sb.push_back('{"reset invuln", 32'd0});
        sb.push_back('{"reset game_over", 32'd0});
        obs.push_back(32'(b_x));
        obs.push_back(32'(b_y));
        obs.push_back(32'(facing));
        obs.push_back(32'(moving));
        obs.push_back(32'(lives));
        obs.push_back(32'(invuln));
        obs.push_back(32'(game_over));
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_step_pacing();
        R = 1'b1;
        sb.push_back('{"no move before 4 cycles", 32'd143});
        cycles(3);
        obs.push_back(32'(b_x));
        sb.push_back('{"first move at cycle 4", 32'd144});
        cycles(1);
        obs.push_back(32'(b_x));
        sb.push_back('{"b_x after 12 cycles", 32'd146});
        sb.push_back('{"facing right", 32'd3});
        sb.push_back('{"moving while held", 32'd1});
        cycles(8);
        obs.push_back(32'(b_x));
        obs.push_back(32'(facing));
        obs.push_back(32'(moving));
        R = 1'b0;
        sb.push_back('{"moving after release", 32'd0});
        sb.push_back('{"step_cnt after release", 32'd0});
        #1;
        obs.push_back(32'(moving));
        cycles(1);
        obs.push_back(32'(dut.step_cnt));
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_blocking();
        // Back to the left wall, then push into it.
        L = 1'b1;
        sb.push_back('{"left wall b_x", 32'd143});
        sb.push_back('{"left wall facing", 32'd2});
        cycles(20);
        obs.push_back(32'(b_x));
        obs.push_back(32'(facing));
        L = 1'b0;
        cycles(1);
        // Walk to (200,100): 57 steps right, 66 steps down.
        R = 1'b1;
        cycles(57 * 4);
        R = 1'b0;
        cycles(1);
        D = 1'b1;
        cycles(66 * 4);
        D = 1'b0;
        cycles(1);
        sb.push_back('{"walk b_x", 32'd200});
        sb.push_back('{"walk b_y", 32'd100});
        obs.push_back(32'(b_x));
        obs.push_back(32'(b_y));
        blocked = 4'b1000;
        D = 1'b1;
        sb.push_back('{"blocked down b_y", 32'd100});
        sb.push_back('{"blocked down facing", 32'd0});
        cycles(8);
        obs.push_back(32'(b_y));
        obs.push_back(32'(facing));
        D = 1'b0;
        blocked = 4'b0000;
        L = 1'b1;
        U = 1'b1;
        sb.push_back('{"L+U moving", 32'd0});
        sb.push_back('{"L+U b_x", 32'd200});
        sb.push_back('{"L+U b_y", 32'd100});
        #1;
        obs.push_back(32'(moving));
        cycles(8);
        obs.push_back(32'(b_x));
        obs.push_back(32'(b_y));
        L = 1'b0;
        U = 1'b0;
        cycles(1);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_sprite_on();
        for (int vx = 198; vx <= 217; vx++) begin
            v_x = 10'(vx);
            v_y = 10'd107;
            sb.push_back('{$sformatf("sprite_on vx=%0d", vx), 32'(vx >= 200 && vx <= 215)});
            #1;
            obs.push_back(32'(sprite_on));
        end
        for (int vy = 98; vy <= 117; vy++) begin
            v_x = 10'd207;
            v_y = 10'(vy);
            sb.push_back('{$sformatf("sprite_on vy=%0d", vy), 32'(vy >= 100 && vy <= 115)});
            #1;
            obs.push_back(32'(sprite_on));
        end
        v_x = 10'd0;
        v_y = 10'd0;
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_explosion();
        // Beam left edge 232 lies past the sprite's right edge 215.
        e_x = 10'd280;
        e_y = 10'd100;
        explosion_p = 1'b1;
        sb.push_back('{"miss lives", 32'd3});
        sb.push_back('{"miss invuln", 32'd0});
        cycles(1);
        explosion_p = 1'b0;
        obs.push_back(32'(lives));
        obs.push_back(32'(invuln));
        // Beam left edge 184 reaches the sprite.
        e_x = 10'd232;
        explosion_p = 1'b1;
        sb.push_back('{"hit lives", 32'd2});
        sb.push_back('{"hit invuln", 32'd1});
        cycles(1);
        explosion_p = 1'b0;
        obs.push_back(32'(lives));
        obs.push_back(32'(invuln));
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_invuln();
        // Entered right after the hit edge: inv_cnt is 0.
        cycles(3);
        enemy_p = 1'b1;
        sb.push_back('{"hit ignored at inv_cnt 3", 32'd2});
        cycles(1);
        enemy_p = 1'b0;
        obs.push_back(32'(lives));
        sb.push_back('{"invuln at inv_cnt 7", 32'd1});
        cycles(3);
        obs.push_back(32'(invuln));
        enemy_p = 1'b1;
        sb.push_back('{"hit ignored at inv_cnt 7", 32'd2});
        sb.push_back('{"invuln drops after 8", 32'd0});
        cycles(1);
        enemy_p = 1'b0;
        obs.push_back(32'(lives));
        obs.push_back(32'(invuln));
        enemy_p = 1'b1;
        sb.push_back('{"hit after invuln lives", 32'd1});
        sb.push_back('{"hit after invuln invuln", 32'd1});
        cycles(1);
        enemy_p = 1'b0;
        obs.push_back(32'(lives));
        obs.push_back(32'(invuln));
        sb.push_back('{"second invuln ends", 32'd0});
        cycles(8);
        obs.push_back(32'(invuln));
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_game_over();
        e_x = 10'd232;
        e_y = 10'd100;
        explosion_p = 1'b1;
        enemy_p = 1'b1;
        sb.push_back('{"dead lives", 32'd0});
        sb.push_back('{"dead game_over", 32'd1});
        sb.push_back('{"dead invuln", 32'd0});
        cycles(1);
        explosion_p = 1'b0;
        enemy_p = 1'b0;
        obs.push_back(32'(lives));
        obs.push_back(32'(game_over));
        obs.push_back(32'(invuln));
        R = 1'b1;
        sb.push_back('{"dead b_x frozen", 32'd200});
        sb.push_back('{"dead moving", 32'd0});
        sb.push_back('{"dead lives held", 32'd0});
        cycles(20);
        obs.push_back(32'(b_x));
        obs.push_back(32'(moving));
        obs.push_back(32'(lives));
        R = 1'b0;
        reset = 1'b0;
        sb.push_back('{"async reset b_x", 32'd143});
        sb.push_back('{"async reset b_y", 32'd34});
        sb.push_back('{"async reset lives", 32'd3});
        sb.push_back('{"async reset game_over", 32'd0});
        sb.push_back('{"async reset facing", 32'd0});
        #2;
        obs.push_back(32'(b_x));
        obs.push_back(32'(b_y));
        obs.push_back(32'(lives));
        obs.push_back(32'(game_over));
        obs.push_back(32'(facing));
        cycles(1);
        reset = 1'b1;
        cycles(1);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %0d expected %0d", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        L           = 1'b0;
        U           = 1'b0;
        R           = 1'b0;
        D           = 1'b0;
        blocked     = 4'b0000;
        explosion_p = 1'b0;
        enemy_p     = 1'b0;
        e_x         = 10'd0;
        e_y         = 10'd0;
        v_x         = 10'd0;
        v_y         = 10'd0;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        test_reset();
        test_step_pacing();
        test_blocking();
        test_sprite_on();
        test_explosion();
        test_invuln();
        test_game_over();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
